// File: rtl/sec_bcd_counter.sv
// Seconds stage: prescales the system clock to a 1 s tick and keeps a two-digit BCD
// seconds value (00-59) with up/down count, pause, clear, load and minute carry/borrow.
module sec_bcd_counter #(
    parameter int DIV = 50000000,
    parameter int PW  = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       up,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_unit,
    input  logic [2:0] load_tens,
    output logic [3:0] unit_sec,
    output logic [2:0] tens_sec,
    output logic       sec_tick,
    output logic       min_carry,
    output logic       min_borrow,
    output logic       is_zero
);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    unit_q, unit_d;
    logic [2:0]    tens_q, tens_d;
    logic          tick_q, tick_d;
    logic          carry_q, carry_d;
    logic          borrow_q, borrow_d;
    logic          tick_int;

    // Out-of-range load digits clamp to the largest legal digit.
    function automatic logic [3:0] sat_unit(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    function automatic logic [2:0] sat_tens(input logic [2:0] v);
        return (v > 3'd5) ? 3'd5 : v;
    endfunction

    assign tick_int = run && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d  = presc_q;
        unit_d   = unit_q;
        tens_d   = tens_q;
        tick_d   = 1'b0;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (clr) begin
            presc_d = '0;
            unit_d  = 4'd0;
            tens_d  = 3'd0;
        end else if (load) begin
            presc_d = '0;
            unit_d  = sat_unit(load_unit);
            tens_d  = sat_tens(load_tens);
        end else if (tick_int) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (up) begin
                if (unit_q >= 4'd9) begin
                    unit_d = 4'd0;
                    if (tens_q >= 3'd5) begin
                        tens_d  = 3'd0;
                        carry_d = 1'b1;
                    end else begin
                        tens_d = tens_q + 3'd1;
                    end
                end else begin
                    unit_d = unit_q + 4'd1;
                end
            end else begin
                if (unit_q == 4'd0) begin
                    unit_d = 4'd9;
                    if (tens_q == 3'd0) begin
                        tens_d   = 3'd5;
                        borrow_d = 1'b1;
                    end else begin
                        tens_d = tens_q - 3'd1;
                    end
                end else begin
                    unit_d = unit_q - 4'd1;
                end
            end
        end else if (run) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q  <= '0;
            unit_q   <= 4'd0;
            tens_q   <= 3'd0;
            tick_q   <= 1'b0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            unit_q   <= unit_d;
            tens_q   <= tens_d;
            tick_q   <= tick_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign unit_sec   = unit_q;
    assign tens_sec   = tens_q;
    assign sec_tick   = tick_q;
    assign min_carry  = carry_q;
    assign min_borrow = borrow_q;
    assign is_zero    = (unit_q == 4'd0) && (tens_q == 3'd0);

endmodule

// File: tb/tb_sec_bcd_counter.sv
// Bench for sec_bcd_counter with DIV=4: per-cycle vector table checked through an
// expectation queue, plus a generated 120-tick up-count run.
module tb_sec_bcd_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, run = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
    logic [3:0] load_unit = 4'd0;
    logic [2:0] load_tens = 3'd0;
    logic [3:0] unit_sec;
    logic [2:0] tens_sec;
    logic       sec_tick, min_carry, min_borrow, is_zero;

    sec_bcd_counter #(.DIV(4), .PW(3)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .up(up), .clr(clr), .load(load),
        .load_unit(load_unit), .load_tens(load_tens),
        .unit_sec(unit_sec), .tens_sec(tens_sec), .sec_tick(sec_tick),
        .min_carry(min_carry), .min_borrow(min_borrow), .is_zero(is_zero)
    );

    always #5 clk = ~clk;

    // ctl = {rst_n, run, up, clr, load}; fl = {sec_tick, min_carry, min_borrow}
    typedef struct {
        string      nm;
        logic [4:0] ctl;
        logic [3:0] lu;
        logic [2:0] lt;
        logic [3:0] eu;
        logic [2:0] et;
        logic [2:0] fl;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   ncarry = 0;
    int   bcd_bad = 0;

    function automatic void add(input int n, input string nm, input logic [4:0] ctl,
                                input logic [3:0] lu, input logic [2:0] lt,
                                input logic [3:0] eu, input logic [2:0] et,
                                input logic [2:0] fl);
        vec_t v;
        v.nm = nm; v.ctl = ctl; v.lu = lu; v.lt = lt; v.eu = eu; v.et = et; v.fl = fl;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic step(input vec_t v);
        vec_t       e;
        logic [10:0] got, want;
        @(negedge clk);
        {rst_n, run, up, clr, load} = v.ctl;
        load_unit = v.lu;
        load_tens = v.lt;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e    = exp_q.pop_front();
        got  = {unit_sec, tens_sec, sec_tick, min_carry, min_borrow, is_zero};
        want = {e.eu, e.et, e.fl, (e.eu == 4'd0) && (e.et == 3'd0)};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got u=%0d t=%0d tick/cy/bw=%b z=%b, want u=%0d t=%0d tick/cy/bw=%b z=%b",
                     e.nm, unit_sec, tens_sec, {sec_tick, min_carry, min_borrow}, is_zero,
                     e.eu, e.et, e.fl, want[0]);
        end
        if (min_carry === 1'b1) ncarry++;
        if (unit_sec > 4'd9 || tens_sec > 3'd5) bcd_bad++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and first tick after release
        add(2, "reset",     5'b01100, 4'd0, 3'd0, 4'd0, 3'd0, 3'b000);
        add(3, "rel_wait",  5'b11100, 4'd0, 3'd0, 4'd0, 3'd0, 3'b000);
        add(1, "first_tick",5'b11100, 4'd0, 3'd0, 4'd1, 3'd0, 3'b100);
        add(1, "tick_1cyc", 5'b11100, 4'd0, 3'd0, 4'd1, 3'd0, 3'b000);
        // Up wrap from 58
        add(1, "load58",    5'b11101, 4'd8, 3'd5, 4'd8, 3'd5, 3'b000);
        add(3, "wait58",    5'b11100, 4'd0, 3'd0, 4'd8, 3'd5, 3'b000);
        add(1, "tick59",    5'b11100, 4'd0, 3'd0, 4'd9, 3'd5, 3'b100);
        add(3, "wait59",    5'b11100, 4'd0, 3'd0, 4'd9, 3'd5, 3'b000);
        add(1, "carry00",   5'b11100, 4'd0, 3'd0, 4'd0, 3'd0, 3'b110);
        add(1, "carry_end", 5'b11100, 4'd0, 3'd0, 4'd0, 3'd0, 3'b000);
        // Down count and borrow wrap
        add(1, "load10",    5'b11001, 4'd0, 3'd1, 4'd0, 3'd1, 3'b000);
        add(3, "wait10",    5'b11000, 4'd0, 3'd0, 4'd0, 3'd1, 3'b000);
        add(1, "tick09",    5'b11000, 4'd0, 3'd0, 4'd9, 3'd0, 3'b100);
        add(1, "load01",    5'b11001, 4'd1, 3'd0, 4'd1, 3'd0, 3'b000);
        add(3, "wait01",    5'b11000, 4'd0, 3'd0, 4'd1, 3'd0, 3'b000);
        add(1, "tick00",    5'b11000, 4'd0, 3'd0, 4'd0, 3'd0, 3'b100);
        add(3, "wait00",    5'b11000, 4'd0, 3'd0, 4'd0, 3'd0, 3'b000);
        add(1, "borrow59",  5'b11000, 4'd0, 3'd0, 4'd9, 3'd5, 3'b101);
        add(1, "borrow_end",5'b11000, 4'd0, 3'd0, 4'd9, 3'd5, 3'b000);
        // Pause keeps the partial prescaler count
        add(1, "clr_run",   5'b11110, 4'd0, 3'd0, 4'd0, 3'd0, 3'b000);
        add(3, "run3",      5'b11100, 4'd0, 3'd0, 4'd0, 3'd0, 3'b000);
        add(10,"paused",    5'b10100, 4'd0, 3'd0, 4'd0, 3'd0, 3'b000);
        add(1, "resume",    5'b11100, 4'd0, 3'd0, 4'd1, 3'd0, 3'b100);
        // Priority and saturation
        add(1, "load_sat",  5'b11101, 4'hF, 3'd7, 4'd9, 3'd5, 3'b000);
        add(1, "clr_load",  5'b11111, 4'd3, 3'd2, 4'd0, 3'd0, 3'b000);
        add(3, "wait_lt",   5'b11100, 4'd0, 3'd0, 4'd0, 3'd0, 3'b000);
        add(1, "load_tick", 5'b11101, 4'd3, 3'd2, 4'd3, 3'd2, 3'b000);
        add(1, "post_load", 5'b11100, 4'd0, 3'd0, 4'd3, 3'd2, 3'b000);
        add(2, "wait_ct",   5'b11100, 4'd0, 3'd0, 4'd3, 3'd2, 3'b000);
        add(1, "clr_tick",  5'b11110, 4'd0, 3'd0, 4'd0, 3'd0, 3'b000);
        // Direction only matters in the tick cycle
        add(3, "dir_down",  5'b11000, 4'd0, 3'd0, 4'd0, 3'd0, 3'b000);
        add(1, "dir_tick",  5'b11100, 4'd0, 3'd0, 4'd1, 3'd0, 3'b100);
        add(1, "paused_clr",5'b10010, 4'd0, 3'd0, 4'd0, 3'd0, 3'b000);
        // Long run: 120 ticks up from 00
        add(1, "long_clr",  5'b11110, 4'd0, 3'd0, 4'd0, 3'd0, 3'b000);
        for (int c = 1; c <= 480; c++) begin
            int   v;
            logic tk;
            tk = (c % 4 == 0);
            v  = (c / 4) % 60;
            add(1, "long_run", 5'b11100, 4'd0, 3'd0, 4'(v % 10), 3'(v / 10),
                {tk, tk && (v == 0), 1'b0});
        end

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        total++;
        if (ncarry != 3) begin
            bad++;
            $display("FAIL carry_count: got %0d carry pulses, want 3", ncarry);
        end
        total++;
        if (bcd_bad != 0) begin
            bad++;
            $display("FAIL bcd_range: got %0d out-of-range cycles, want 0", bcd_bad);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
